// File: rtl/dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dma_pkg                                                          |
// | Purpose : Shared definitions for the DMA channel sequencer: datapath       |
// |           instruction codes, FSM state encoding, default bus timeout and   |
// |           the state-to-output decode used by dma_seq.                      |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package dma_pkg;

  // Datapath instruction codes
  localparam logic [2:0] LDCR = 3'b000;
  localparam logic [2:0] RDAR = 3'b011;  // no-op: changes no datapath state
  localparam logic [2:0] INIT = 3'b100;
  localparam logic [2:0] LDAR = 3'b101;
  localparam logic [2:0] LDWR = 3'b110;
  localparam logic [2:0] STEP = 3'b111;

  // Sequencer state encoding
  typedef logic [3:0] state_t;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] S_CR     = 4'd1;
  localparam logic [3:0] S_AR     = 4'd2;
  localparam logic [3:0] S_WR     = 4'd3;
  localparam logic [3:0] S_INIT   = 4'd4;
  localparam logic [3:0] WAIT_REQ = 4'd5;
  localparam logic [3:0] BUS_REQ  = 4'd6;
  localparam logic [3:0] XFER     = 4'd7;
  localparam logic [3:0] CHECK    = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  localparam int unsigned BUS_TIMEOUT_DEFAULT = 16;

  // Moore outputs of the sequencer
  typedef struct packed {
    logic [2:0] instr;
    logic [7:0] data_out;
    logic       breq;
    logic       dack;
    logic       busy;
  } seq_out_t;

  // Every output is a pure function of the state register and the shadow
  // registers, so no input reaches an output combinationally.
  function automatic seq_out_t decode_state(input state_t     st,
                                            input logic [2:0] cr,
                                            input logic [7:0] addr,
                                            input logic [7:0] words);
    seq_out_t o;
    o.instr    = RDAR;
    o.data_out = 8'h00;
    o.breq     = 1'b0;
    o.dack     = 1'b0;
    o.busy     = (st != IDLE);
    case (st)
      S_CR: begin
        o.instr    = LDCR;
        o.data_out = {5'b0, cr};
      end
      S_AR: begin
        o.instr    = LDAR;
        o.data_out = addr;
      end
      S_WR: begin
        o.instr    = LDWR;
        o.data_out = words;
      end
      S_INIT:  o.instr = INIT;
      BUS_REQ: o.breq  = 1'b1;
      XFER: begin
        o.instr = STEP;
        o.breq  = 1'b1;
        o.dack  = 1'b1;
      end
      CHECK:   o.breq  = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_seq_bus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_timer                                                        |
// | Purpose : Bus-grant wait timer. Counts enabled cycles from zero and flags  |
// |           the last permitted cycle of a LIMIT-cycle window.                |
// | Ports   : clk    in   clock                                                |
// |           reset  in   synchronous active-high reset                        |
// |           clear  in   force count to zero (dominates enable)               |
// |           enable in   advance the count by one                             |
// |           expire out  count has reached LIMIT-1                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bus_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      // Saturate so a stalled owner can never wrap back into the window.
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/dma_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dma_seq                                                          |
// | Purpose : Sequencer for a DMA channel datapath. On start it programs CR,   |
// |           AR and WR, issues INIT, then services peripheral requests with   |
// |           a bus request/grant handshake per transfer, and raises irq when  |
// |           the datapath reports done. A grant that never arrives within     |
// |           BUS_TIMEOUT cycles abandons the job and sets err.                |
// | Config  : DMA_SEQ_AUTOINIT_EN - when defined, completion re-issues INIT    |
// |           and keeps servicing requests until abort or reset.               |
// | Ports   : clk, reset (sync, active high)                                   |
// |           start, abort, cfg_cr[2:0], cfg_addr[7:0], cfg_words[7:0],        |
// |           burst, dreq, bgnt, done, irq_clr                   (inputs)      |
// |           instr[2:0], data_out[7:0], breq, dack, busy, irq, err (outputs)  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dma_seq
  import dma_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] cfg_cr,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_words,
  input  logic       burst,
  input  logic       dreq,
  input  logic       bgnt,
  input  logic       done,
  input  logic       irq_clr,
  output logic [2:0] instr,
  output logic [7:0] data_out,
  output logic       breq,
  output logic       dack,
  output logic       busy,
  output logic       irq,
  output logic       err
);

  state_t     state;
  state_t     next_state;
  logic [2:0] cr_sh;
  logic [7:0] addr_sh;
  logic [7:0] words_sh;

  logic       start_acc;
  logic       irq_set;
  logic       err_set;
  logic       timer_expire;
  seq_out_t   dec;

  // Timer runs only while requesting the bus and is held at zero elsewhere,
  // so every entry into BUS_REQ starts a fresh window.
  bus_timer #(
    .LIMIT (BUS_TIMEOUT)
  ) u_bus_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != BUS_REQ),
    .enable (state == BUS_REQ),
    .expire (timer_expire)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = S_CR;
      S_CR:     next_state = S_AR;
      S_AR:     next_state = S_WR;
      S_WR:     next_state = S_INIT;
      S_INIT:   next_state = WAIT_REQ;
      WAIT_REQ: if (dreq) next_state = BUS_REQ;
      // dreq is not re-examined here: once requested, the transfer is
      // committed and completes on grant.
      BUS_REQ: begin
        if (bgnt)              next_state = XFER;
        else if (timer_expire) next_state = IDLE;
      end
      XFER:     next_state = CHECK;
      // done is looked at one cycle after STEP so it reflects the
      // updated counters.
      CHECK: begin
        if (done)                        next_state = DONE;
        else if (burst && dreq && bgnt)  next_state = XFER;
        else                             next_state = WAIT_REQ;
      end
`ifdef DMA_SEQ_AUTOINIT_EN
      DONE:     next_state = S_INIT;
`else
      DONE:     next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  assign start_acc = (state == IDLE) && start && !abort;
  // irq is set on the way into DONE so it is already visible while DONE
  // is the current state.
  assign irq_set   = (state == CHECK) && done && !abort;
  assign err_set   = (state == BUS_REQ) && !bgnt && timer_expire && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cr_sh    <= 3'b000;
      addr_sh  <= 8'h00;
      words_sh <= 8'h00;
      irq      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (start_acc) begin
        cr_sh    <= cfg_cr;
        addr_sh  <= cfg_addr;
        words_sh <= cfg_words;
      end
      if (irq_set)                   irq <= 1'b1;
      else if (irq_clr || start_acc) irq <= 1'b0;
      if (err_set)                   err <= 1'b1;
      else if (start_acc)            err <= 1'b0;
    end
  end

  assign dec      = decode_state(state, cr_sh, addr_sh, words_sh);
  assign instr    = dec.instr;
  assign data_out = dec.data_out;
  assign breq     = dec.breq;
  assign dack     = dec.dack;
  assign busy     = dec.busy;

endmodule
`default_nettype wire

// File: tb/tb_dma_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dma_seq                                                       |
// | Purpose : Self-checking bench for dma_seq. A behavioural datapath counter  |
// |           provides done; transfer timing expectations come from the        |
// |           handshake rules. Honours DMA_SEQ_AUTOINIT_EN.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dma_seq;

  localparam logic [2:0] C_LDCR = 3'b000;
  localparam logic [2:0] C_RDAR = 3'b011;
  localparam logic [2:0] C_INIT = 3'b100;
  localparam logic [2:0] C_LDAR = 3'b101;
  localparam logic [2:0] C_LDWR = 3'b110;
  localparam logic [2:0] C_STEP = 3'b111;
  localparam int         C_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset, start, abort, burst, dreq, bgnt, irq_clr;
  logic [2:0] cfg_cr;
  logic [7:0] cfg_addr, cfg_words;
  logic       done;
  logic [2:0] instr;
  logic [7:0] data_out;
  logic       breq, dack, busy, irq, err;

  int n_checks = 0;
  int n_errors = 0;

  dma_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_cr    (cfg_cr),
    .cfg_addr  (cfg_addr),
    .cfg_words (cfg_words),
    .burst     (burst),
    .dreq      (dreq),
    .bgnt      (bgnt),
    .done      (done),
    .irq_clr   (irq_clr),
    .instr     (instr),
    .data_out  (data_out),
    .breq      (breq),
    .dack      (dack),
    .busy      (busy),
    .irq       (irq),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: word register, word counter and STEP tally.
  logic [7:0] dp_wr  = 8'd0;
  logic [7:0] dp_cnt = 8'd0;
  int         steps  = 0;
  always @(posedge clk) begin
    if (instr == C_LDWR) dp_wr <= data_out;
    if (instr == C_INIT) begin
      dp_cnt <= dp_wr;
      steps  <= 0;
    end
    if (instr == C_STEP) begin
      dp_cnt <= dp_cnt - 8'd1;
      steps  <= steps + 1;
    end
  end
  assign done = (dp_cnt == 8'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_instr"}, 32'(instr), 32'(C_RDAR));
    check_eq({tag, "_data"},  32'(data_out), 32'd0);
    check_eq({tag, "_breq"},  32'(breq), 32'd0);
    check_eq({tag, "_dack"},  32'(dack), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_irq"},   32'(irq), 32'd0);
    check_eq({tag, "_err"},   32'(err), 32'd0);
  endtask

  // Start pulse, then four programming cycles, landing in the request wait.
  task automatic program_job(input logic [2:0] cr, input logic [7:0] a, input logic [7:0] w);
    cfg_cr = cr; cfg_addr = a; cfg_words = w; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_cr = 3'($urandom); cfg_addr = 8'($urandom); cfg_words = 8'($urandom);
    check_eq("prog_cr_instr", 32'(instr), 32'(C_LDCR));
    check_eq("prog_cr_data",  32'(data_out), 32'({5'b0, cr}));
    check_eq("prog_busy",     32'(busy), 32'd1);
    check_eq("prog_irq_clr",  32'(irq), 32'd0);
    check_eq("prog_err_clr",  32'(err), 32'd0);
    tick();
    check_eq("prog_ar_instr", 32'(instr), 32'(C_LDAR));
    check_eq("prog_ar_data",  32'(data_out), 32'(a));
    tick();
    check_eq("prog_wr_instr", 32'(instr), 32'(C_LDWR));
    check_eq("prog_wr_data",  32'(data_out), 32'(w));
    tick();
    check_eq("prog_init",     32'(instr), 32'(C_INIT));
    tick();
    check_eq("wait_instr",    32'(instr), 32'(C_RDAR));
    check_eq("wait_busy",     32'(busy), 32'd1);
    check_eq("wait_breq",     32'(breq), 32'd0);
  endtask

  // One non-burst transfer with the grant arriving after g idle BUS_REQ cycles.
  task automatic xfer_single(input bit last, input int g, input bit clr_race);
    dreq = 1'b1;
    tick();
    check_eq("req_breq", 32'(breq), 32'd1);
    check_eq("req_dack", 32'(dack), 32'd0);
    if ($urandom_range(0, 1) == 1) dreq = 1'b0;  // request stays committed
    for (int k = 0; k < g; k++) begin
      tick();
      check_eq("req_hold", 32'(breq), 32'd1);
    end
    bgnt = 1'b1;
    tick();
    dreq = 1'b0; bgnt = 1'b0;
    check_eq("xfer_dack",  32'(dack), 32'd1);
    check_eq("xfer_instr", 32'(instr), 32'(C_STEP));
    check_eq("xfer_breq",  32'(breq), 32'd1);
    tick();
    check_eq("chk_dack",  32'(dack), 32'd0);
    check_eq("chk_breq",  32'(breq), 32'd1);
    check_eq("chk_instr", 32'(instr), 32'(C_RDAR));
    if (clr_race) irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("post_breq", 32'(breq), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd1);
    check_eq(last ? "done_irq" : "release_irq", 32'(irq), last ? 32'd1 : 32'd0);
  endtask

  task automatic finish_job();
`ifdef DMA_SEQ_AUTOINIT_EN
    tick();
    check_eq("auto_init_instr", 32'(instr), 32'(C_INIT));
    check_eq("auto_init_busy",  32'(busy), 32'd1);
    check_eq("auto_init_irq",   32'(irq), 32'd1);
    tick();
    check_eq("auto_wait_instr", 32'(instr), 32'(C_RDAR));
    check_eq("auto_wait_busy",  32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("auto_abort_busy", 32'(busy), 32'd0);
    check_eq("auto_abort_irq",  32'(irq), 32'd1);
`else
    tick();
    check_eq("end_busy",  32'(busy), 32'd0);
    check_eq("end_instr", 32'(instr), 32'(C_RDAR));
    check_eq("end_irq",   32'(irq), 32'd1);
`endif
  endtask

  task automatic single_job(input logic [7:0] w, input int fixed_g);
    int g;
    program_job(3'($urandom), 8'($urandom), w);
    burst = 1'b0;
    for (int i = 0; i < int'(w); i++) begin
      g = (fixed_g >= 0) ? fixed_g : int'($urandom_range(0, C_TIMEOUT - 1));
      xfer_single(i == int'(w) - 1, g, (i == int'(w) - 1) && ($urandom_range(0, 1) == 1));
    end
    check_eq("single_steps", 32'(steps), 32'(w));
    finish_job();
  endtask

  // Held dreq/bgnt with burst: BUS_REQ once, then XFER/CHECK pairs.
  task automatic burst_job(input logic [7:0] w);
    int nb, nd, cyc;
    program_job(3'($urandom), 8'($urandom), w);
    burst = 1'b1; dreq = 1'b1; bgnt = 1'b1;
    nb = 0; nd = 0; cyc = 0;
    while (irq !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
      if (breq === 1'b1) nb++;
      if (dack === 1'b1) nd++;
    end
    burst = 1'b0; dreq = 1'b0; bgnt = 1'b0;
    check_eq("burst_bound", 32'(cyc < 80), 32'd1);
    check_eq("burst_breq_cycles", 32'(nb), 32'(2 * int'(w) + 1));
    check_eq("burst_dacks", 32'(nd), 32'(w));
    check_eq("burst_steps", 32'(steps), 32'(w));
    finish_job();
  endtask

  task automatic timeout_job();
    int n;
    program_job(3'($urandom), 8'($urandom), 8'd4);
    dreq = 1'b1; bgnt = 1'b0;
    tick();
    n = 0;
    while (breq === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    dreq = 1'b0;
    check_eq("tmo_breq_cycles", 32'(n), 32'(C_TIMEOUT));
    check_eq("tmo_err",  32'(err), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    check_eq("tmo_irq",  32'(irq), 32'd0);
    check_eq("tmo_dack_steps", 32'(steps), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; burst = 1'b0; dreq = 1'b0;
    bgnt = 1'b0; irq_clr = 1'b0; cfg_cr = 3'd0; cfg_addr = 8'd0; cfg_words = 8'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed program + three single transfers with a one-cycle grant delay.
    program_job(3'b000, 8'h40, 8'h03);
    for (int i = 0; i < 3; i++) xfer_single(i == 2, 1, i == 2);
    check_eq("dir_steps", 32'(steps), 32'd3);
    finish_job();

    burst_job(8'd4);
    timeout_job();
    single_job(8'd1, C_TIMEOUT - 1);  // grant on the last permitted cycle

    for (int j = 0; j < 6; j++) begin
      if ($urandom_range(0, 1) == 1) burst_job(8'($urandom_range(1, 6)));
      else                           single_job(8'($urandom_range(1, 5)), -1);
    end

    // Start and abort together in IDLE: nothing is programmed, irq held.
    start = 1'b1; abort = 1'b1; cfg_words = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("sa_busy",  32'(busy), 32'd0);
    check_eq("sa_irq",   32'(irq), 32'd1);
    check_eq("sa_instr", 32'(instr), 32'(C_RDAR));
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("irq_clr", 32'(irq), 32'd0);

    // Abort during XFER.
    program_job(3'b001, 8'h10, 8'd3);
    dreq = 1'b1;
    tick();
    bgnt = 1'b1;
    tick();
    check_eq("ab_xfer_dack", 32'(dack), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0; bgnt = 1'b0; dreq = 1'b0;
    check_eq("ab_dack", 32'(dack), 32'd0);
    check_eq("ab_breq", 32'(breq), 32'd0);
    check_eq("ab_busy", 32'(busy), 32'd0);
    check_eq("ab_irq",  32'(irq), 32'd0);

    // Reset while requesting the bus.
    program_job(3'b101, 8'hA5, 8'd2);
    dreq = 1'b1;
    tick();
    check_eq("rst_pre_breq", 32'(breq), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; dreq = 1'b0;
    check_reset_outputs("midreset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
